// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_pkg
//  Purpose  : Shared types and defaults for the fast-to-slow pulse crossing.
//  Revision : 1.0  initial release
// ============================================================================
package cdc_pkg;

    // Per-lane transmit handshake states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } cdc_tx_state_e;

    localparam int CDC_SYNC_STAGES_DEF = 2;
    localparam int CDC_WIDTH_DEF       = 8;
    localparam int CDC_CNT_W_DEF       = 8;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/cdc_pulse_req_fast_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_pulse_req_fast_tx_if
//  Purpose  : Pulse/handshake/status bundle of the fast-domain transmitter.
//             master = event source / receiver side, slave = transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface cdc_pulse_req_fast_tx_if
    import cdc_pkg::*;
#(
    parameter int WIDTH = CDC_WIDTH_DEF,
    parameter int CNT_W = CDC_CNT_W_DEF
);
    logic [WIDTH-1:0] pulse_in_fast;
    logic [WIDTH-1:0] ack_in_async;
    logic             ovf_clr;
    logic [WIDTH-1:0] req_out;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] overflow;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output pulse_in_fast, ack_in_async, ovf_clr,
        input  req_out, busy, overflow, drop_cnt
    );

    modport slave (
        input  pulse_in_fast, ack_in_async, ovf_clr,
        output req_out, busy, overflow, drop_cnt
    );
endinterface : cdc_pulse_req_fast_tx_if
`default_nettype wire

// File: rtl/cdc_pulse_req_lane.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_pulse_req_lane
//  Purpose  : One lane: four-phase req/ack transmitter with a one-deep
//             pending slot and an ack synchronizer. Flags dropped pulses.
//  Revision : 1.0  initial release
// ============================================================================
module cdc_pulse_req_lane
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
    input  wire logic fast_clk,
    input  wire logic reset_n,
    input  wire logic pulse_i,
    input  wire logic ack_async_i,
    output logic      req_o,
    output logic      busy_o,
    output logic      drop_o
);

    cdc_tx_state_e          state_q, state_d;
    logic                   pending_q, pending_d;
    logic                   req_q, req_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   exit_wait;
    logic                   direct;
    logic                   consume;

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Ack synchronizer chain from the slow domain.
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async_i};
        end
    end

    // Next state, pending slot and drop decision.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        drop_o    = 1'b0;

        // Leaving WAIT_LOW this cycle: either the pending pulse or a pulse
        // arriving right now starts the next request.
        exit_wait = (state_q == WAIT_LOW) && !ack_s;
        direct    = (state_q == IDLE) || (exit_wait && !pending_q);
        consume   = exit_wait && pending_q;

        case (state_q)
            IDLE:     if (pulse_i) state_d = REQ;
            REQ:      if (ack_s)   state_d = WAIT_LOW;
            WAIT_LOW: if (!ack_s)  state_d = (pending_q || pulse_i) ? REQ : IDLE;
            default:               state_d = IDLE;
        endcase

        if (pulse_i && !direct) begin
            // A consumed slot may be refilled in the same cycle.
            if (!pending_q || consume) begin
                pending_d = 1'b1;
            end else begin
                drop_o = 1'b1;
            end
        end else if (consume) begin
            pending_d = 1'b0;
        end

        req_d = (state_d == REQ);
    end

    // State, pending and request registers; request leaves straight from a flop.
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
        end
    end

    assign req_o  = req_q;
    assign busy_o = (state_q != IDLE);

endmodule : cdc_pulse_req_lane
`default_nettype wire

// File: rtl/cdc_pulse_req_fast_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_pulse_req_fast_tx
//  Purpose  : WIDTH independent pulse-to-handshake lanes toward a slower
//             domain, with sticky per-lane overflow and a saturating
//             shared drop counter.
//  Revision : 1.0  initial release
// ============================================================================
module cdc_pulse_req_fast_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH       = CDC_WIDTH_DEF,
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF,
    parameter int CNT_W       = CDC_CNT_W_DEF
) (
    input  wire logic               fast_clk,
    input  wire logic               reset_n,
    cdc_pulse_req_fast_tx_if.slave  bus
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_req;
    logic [WIDTH-1:0] w_busy;
    logic [WIDTH-1:0] w_drop;
    logic [PC_W-1:0]  drop_pc;
    logic [SUM_W-1:0] cnt_sum;
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        cdc_pulse_req_lane #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_lane (
            .fast_clk    (fast_clk),
            .reset_n     (reset_n),
            .pulse_i     (bus.pulse_in_fast[i]),
            .ack_async_i (bus.ack_in_async[i]),
            .req_o       (w_req[i]),
            .busy_o      (w_busy[i]),
            .drop_o      (w_drop[i])
        );
    end

    // Drop popcount, saturating accumulate, and sticky overflow with clear.
    always_comb begin
        drop_pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drop_pc = drop_pc + PC_W'(w_drop[i]);
        end

        // A clear restarts accounting from this cycle's drops only.
        if (bus.ovf_clr) begin
            cnt_sum    = SUM_W'(drop_pc);
            overflow_d = w_drop;
        end else begin
            cnt_sum    = SUM_W'(drop_cnt_q) + SUM_W'(drop_pc);
            overflow_d = overflow_q | w_drop;
        end

        drop_cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // Status registers.
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.req_out  = w_req;
    assign bus.busy     = w_busy;
    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule : cdc_pulse_req_fast_tx
`default_nettype wire

// File: tb/tb_cdc_pulse_req_fast_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_pulse_req_fast_tx
//  Purpose  : Self-checking bench: a directed vector table, hand sequences
//             for the multi-cycle cases, and randomized traffic compared
//             against a queue-style reference model. Two DUT copies share
//             stimulus: one with an 8-bit and one with a 4-bit drop counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdc_pulse_req_fast_tx;
    import cdc_pkg::*;

    localparam int W = 8;
    localparam int S = 2;

    logic         fast_clk = 1'b0;
    logic         reset_n  = 1'b0;
    logic [W-1:0] pulse    = '0;
    logic [W-1:0] ack      = '0;
    logic         clr      = 1'b0;

    always #5 fast_clk = ~fast_clk;

    cdc_pulse_req_fast_tx_if #(.WIDTH(W), .CNT_W(8)) bus8 ();
    cdc_pulse_req_fast_tx_if #(.WIDTH(W), .CNT_W(4)) bus4 ();

    assign bus8.pulse_in_fast = pulse;
    assign bus8.ack_in_async  = ack;
    assign bus8.ovf_clr       = clr;
    assign bus4.pulse_in_fast = pulse;
    assign bus4.ack_in_async  = ack;
    assign bus4.ovf_clr       = clr;

    cdc_pulse_req_fast_tx #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(8)) u_dut8 (
        .fast_clk (fast_clk),
        .reset_n  (reset_n),
        .bus      (bus8.slave)
    );

    cdc_pulse_req_fast_tx #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(4)) u_dut4 (
        .fast_clk (fast_clk),
        .reset_n  (reset_n),
        .bus      (bus4.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Each lane: request level, releasing flag (waiting for ack to fall),
    // backlog of accepted-but-unsent pulses (at most one survives),
    // and the ack value as it looks S-1 edges later.
    bit           m_req [W];
    bit           m_rel [W];
    int           m_bl  [W];
    bit [S-1:0]   m_hist[W];
    logic [W-1:0] m_ovf;
    int           m_cnt8;
    int           m_cnt4;

    // receiver model and bookkeeping
    bit           rx_en;
    int           rx_dly[W];
    int           rx_cnt[W];
    int           rises [W];
    logic [W-1:0] prev_req;

    typedef struct {
        logic [W-1:0] pulse;
        logic [W-1:0] ack;
        logic [W-1:0] exp_req;
        logic [W-1:0] exp_busy;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_req[i]  = 0;
            m_rel[i]  = 0;
            m_bl[i]   = 0;
            m_hist[i] = '0;
            rx_cnt[i] = 0;
            rises[i]  = 0;
        end
        m_ovf    = '0;
        m_cnt8   = 0;
        m_cnt4   = 0;
        prev_req = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] dmask;
        int           nd;
        int           n;
        bit           acks;
        dmask = '0;
        nd    = 0;
        for (int i = 0; i < W; i++) begin
            acks = m_hist[i][S-1];
            if (!m_req[i] && !m_rel[i]) begin
                if (pulse[i]) m_req[i] = 1;
            end else begin
                n = m_bl[i] + int'(pulse[i]);
                if (m_req[i] && acks) begin
                    m_req[i] = 0;
                    m_rel[i] = 1;
                end else if (m_rel[i] && !acks) begin
                    m_rel[i] = 0;
                    if (n > 0) begin
                        m_req[i] = 1;
                        n--;
                    end
                end
                if (n > 1) begin
                    dmask[i] = 1'b1;
                    nd++;
                    n = 1;
                end
                m_bl[i] = n;
            end
            m_hist[i] = {m_hist[i][S-2:0], ack[i]};
        end
        if (clr) begin
            m_ovf  = dmask;
            m_cnt8 = nd;
            m_cnt4 = nd;
        end else begin
            m_ovf  = m_ovf | dmask;
            m_cnt8 = m_cnt8 + nd;
            m_cnt4 = m_cnt4 + nd;
        end
        if (m_cnt8 > 255) m_cnt8 = 255;
        if (m_cnt4 > 15)  m_cnt4 = 15;
    endtask

    task automatic model_check();
        logic [W-1:0] mr;
        logic [W-1:0] mb;
        for (int i = 0; i < W; i++) begin
            mr[i] = m_req[i];
            mb[i] = m_req[i] | m_rel[i];
        end
        chk("req_out", bus8.req_out, mr);
        chk("busy", bus8.busy, mb);
        chk("overflow", bus8.overflow, m_ovf);
        chk("drop_cnt8", bus8.drop_cnt, m_cnt8);
        chk("drop_cnt4", bus4.drop_cnt, m_cnt4);
        chk("req_out_cnt4", bus4.req_out, mr);
    endtask

    // One clock: sample after the edge, check, count rises, run the receiver.
    task automatic tick();
        @(posedge fast_clk);
        #1;
        model_step();
        model_check();
        for (int i = 0; i < W; i++) begin
            if (bus8.req_out[i] === 1'b1 && !prev_req[i]) rises[i]++;
        end
        prev_req = bus8.req_out;
        if (rx_en) begin
            for (int i = 0; i < W; i++) begin
                if (ack[i] != m_req[i]) begin
                    rx_cnt[i]++;
                    if (rx_cnt[i] >= rx_dly[i]) begin
                        ack[i]    = m_req[i];
                        rx_cnt[i] = 0;
                    end
                end else begin
                    rx_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_rises();
        for (int i = 0; i < W; i++) rises[i] = 0;
    endtask

    initial begin
        // single pulse on lane 0, ack supplied by the table
        tbl[0]  = '{8'h01, 8'h00, 8'h01, 8'h01};
        tbl[1]  = '{8'h00, 8'h00, 8'h01, 8'h01};
        tbl[2]  = '{8'h00, 8'h00, 8'h01, 8'h01};
        tbl[3]  = '{8'h00, 8'h01, 8'h01, 8'h01};
        tbl[4]  = '{8'h00, 8'h01, 8'h01, 8'h01};
        tbl[5]  = '{8'h00, 8'h01, 8'h00, 8'h01};
        tbl[6]  = '{8'h00, 8'h01, 8'h00, 8'h01};
        tbl[7]  = '{8'h00, 8'h00, 8'h00, 8'h01};
        tbl[8]  = '{8'h00, 8'h00, 8'h00, 8'h01};
        tbl[9]  = '{8'h00, 8'h00, 8'h00, 8'h00};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 8'h00};

        rx_en = 0;
        for (int i = 0; i < W; i++) rx_dly[i] = 3;
        model_reset();

        // ---------- reset state ----------
        reset_n = 1'b0;
        repeat (3) @(posedge fast_clk);
        #1;
        chk("rst_req", bus8.req_out, 0);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_ovf", bus8.overflow, 0);
        chk("rst_cnt", bus8.drop_cnt, 0);
        @(negedge fast_clk);
        reset_n = 1'b1;
        run(3);

        // ---------- directed table: single handshake ----------
        for (int v = 0; v < 11; v++) begin
            pulse = tbl[v].pulse;
            ack   = tbl[v].ack;
            tick();
            chk($sformatf("tbl%0d_req", v), bus8.req_out, tbl[v].exp_req);
            chk($sformatf("tbl%0d_busy", v), bus8.busy, tbl[v].exp_busy);
            chk($sformatf("tbl%0d_cnt", v), bus8.drop_cnt, 0);
        end
        pulse = '0;

        // ---------- buffered pulse, lane 3 ----------
        rx_en = 1;
        clear_rises();
        pulse = 8'h08; tick();
        pulse = 8'h00; tick();
        pulse = 8'h08; tick();
        pulse = 8'h00;
        run(40);
        chk("buf_handshakes", rises[3], 2);
        chk("buf_ovf", bus8.overflow, 0);
        chk("buf_cnt", bus8.drop_cnt, 0);

        // ---------- drop, lane 5, ack held off ----------
        rx_en = 0;
        ack   = '0;
        clear_rises();
        pulse = 8'h20; tick();
        pulse = 8'h00; tick();
        pulse = 8'h20; tick();
        pulse = 8'h00; tick();
        pulse = 8'h20; tick();
        pulse = 8'h00; tick();
        chk("drop_ovf", bus8.overflow, 8'h20);
        chk("drop_cnt", bus8.drop_cnt, 1);
        rx_en = 1;
        run(40);
        chk("drop_handshakes", rises[5], 2);
        clr = 1'b1; tick();
        clr = 1'b0; tick();
        chk("clr_ovf", bus8.overflow, 0);

        // ---------- saturation and clear ----------
        rx_en = 0;
        ack   = '0;
        pulse = 8'hFF; run(4);
        pulse = 8'h0F; tick();
        pulse = 8'h00; tick();
        chk("sat_cnt4", bus4.drop_cnt, 15);
        chk("sat_cnt8", bus8.drop_cnt, 20);
        pulse = 8'h60;
        clr   = 1'b1;
        tick();
        pulse = 8'h00;
        clr   = 1'b0;
        chk("clr_drop_cnt4", bus4.drop_cnt, 2);
        chk("clr_drop_cnt8", bus8.drop_cnt, 2);
        chk("clr_drop_ovf", bus8.overflow, 8'h60);
        rx_en = 1;
        run(60);
        chk("sat_drained", bus8.busy, 0);

        // ---------- all lanes, per-lane ack delays ----------
        for (int i = 0; i < W; i++) rx_dly[i] = i + 1;
        clear_rises();
        pulse = 8'hFF; tick();
        pulse = 8'h00;
        run(50);
        for (int i = 0; i < W; i++) chk($sformatf("all_hs_lane%0d", i), rises[i], 1);

        // ---------- reset mid-handshake, lane 2 in REQ with pending ----------
        rx_en = 0;
        ack   = '0;
        pulse = 8'h04; tick();
        pulse = 8'h04; tick();
        pulse = 8'h00; tick();
        chk("pre_rst_req2", bus8.req_out, 8'h04);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_req", bus8.req_out, 0);
        chk("arst_busy", bus8.busy, 0);
        chk("arst_ovf", bus8.overflow, 0);
        chk("arst_cnt", bus8.drop_cnt, 0);
        model_reset();
        @(posedge fast_clk);
        #3;
        reset_n = 1'b1;
        run(12);
        chk("post_rst_no_req", rises[2], 0);

        // ---------- randomized traffic ----------
        rx_en = 1;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) begin
                for (int i = 0; i < W; i++) rx_dly[i] = $urandom_range(1, 6);
            end
            for (int i = 0; i < W; i++) pulse[i] = ($urandom_range(0, 99) < 20);
            clr = ($urandom_range(0, 99) < 2);
            tick();
        end
        pulse = '0;
        clr   = 1'b0;
        run(60);
        chk("final_idle", bus8.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cdc_pulse_req_fast_tx
`default_nettype wire
